// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation, instruction SRAM request/response
// handling with a single outstanding fetch, a one-entry instruction buffer for
// decode stalls, and branch redirect with wrong-path cancellation.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_collect,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    logic        fs_valid_q, fs_valid_d;
    logic [31:0] fs_pc_q, fs_pc_d;
    logic        fs_waiting_q, fs_waiting_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;
    logic        br_buf_valid_q, br_buf_valid_d;
    logic [31:0] br_buf_target_q, br_buf_target_d;
    logic        cancel_q, cancel_d;
    logic        req_hold_q, req_hold_d;
    logic [31:0] req_addr_q, req_addr_d;
    // held request was fetched from a redirect target (br_taken or br_buf)
    logic        req_from_br_q, req_from_br_d;
    // held request became wrong-path because a redirect arrived while it waited
    logic        req_stale_q, req_stale_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        fs_ready_go;
    logic        fs_xfer;
    logic        stage_free;
    logic        no_outstanding;
    logic        req_start;
    logic        req_accept;
    logic        stale_now;
    logic        from_br_now;
    logic [31:0] next_pc;

    assign br_taken  = br_collect[32];
    assign br_target = br_collect[31:0];

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // Request generation, decode handshake and redirect bookkeeping helpers
    always_comb begin
        fs_ready_go    = inst_buf_valid_q | (fs_waiting_q & inst_sram_data_ok & ~cancel_q);
        fs_to_ds_valid = ~reset & fs_valid_q & fs_ready_go;
        fs_to_ds_bus   = {(inst_buf_valid_q ? inst_buf_q : inst_sram_rdata), fs_pc_q};
        fs_xfer        = fs_to_ds_valid & ds_allowin;

        no_outstanding = ~fs_waiting_q | inst_sram_data_ok;
        stage_free     = ~fs_valid_q | fs_xfer | br_taken;
        req_start      = ~reset & ~req_hold_q & no_outstanding & stage_free;

        if (br_taken)            next_pc = br_target;
        else if (br_buf_valid_q) next_pc = br_buf_target_q;
        else                     next_pc = fs_pc_q + 32'd4;

        inst_sram_req  = ~reset & (req_hold_q | req_start);
        inst_sram_addr = req_hold_q ? req_addr_q : next_pc;
        req_accept     = inst_sram_req & inst_sram_addr_ok;

        stale_now      = req_hold_q & (req_stale_q | br_taken);
        from_br_now    = req_hold_q ? req_from_br_q : (br_taken | br_buf_valid_q);
    end

    // Next-state computation for all stage registers
    always_comb begin
        fs_valid_d = fs_valid_q;
        if (fs_xfer | br_taken) fs_valid_d = 1'b0;
        if (req_accept)         fs_valid_d = ~stale_now;

        fs_pc_d = req_accept ? inst_sram_addr : fs_pc_q;

        fs_waiting_d = fs_waiting_q;
        if (inst_sram_data_ok) fs_waiting_d = 1'b0;
        if (req_accept)        fs_waiting_d = 1'b1;

        inst_buf_d       = inst_buf_q;
        inst_buf_valid_d = inst_buf_valid_q;
        if (fs_waiting_q & inst_sram_data_ok & ~cancel_q & ~ds_allowin) begin
            inst_buf_d       = inst_sram_rdata;
            inst_buf_valid_d = 1'b1;
        end
        if (fs_xfer | br_taken) inst_buf_valid_d = 1'b0;

        // a target request accepted in the redirect cycle needs no buffering
        br_buf_valid_d  = br_buf_valid_q;
        br_buf_target_d = br_buf_target_q;
        if (req_accept & from_br_now & ~stale_now) br_buf_valid_d = 1'b0;
        if (br_taken & ~(req_accept & ~req_hold_q)) begin
            br_buf_valid_d  = 1'b1;
            br_buf_target_d = br_target;
        end

        cancel_d = cancel_q;
        if (inst_sram_data_ok & cancel_q)                     cancel_d = 1'b0;
        if (br_taken & fs_waiting_q & ~inst_sram_data_ok)     cancel_d = 1'b1;
        if (req_accept & stale_now)                           cancel_d = 1'b1;

        req_hold_d    = inst_sram_req & ~inst_sram_addr_ok;
        req_addr_d    = inst_sram_addr;
        req_stale_d   = req_hold_d & stale_now;
        req_from_br_d = req_hold_d & from_br_now;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_q       <= 1'b0;
            fs_pc_q          <= RESET_PC - 32'd4;
            fs_waiting_q     <= 1'b0;
            inst_buf_q       <= 32'h0;
            inst_buf_valid_q <= 1'b0;
            br_buf_valid_q   <= 1'b0;
            br_buf_target_q  <= 32'h0;
            cancel_q         <= 1'b0;
            req_hold_q       <= 1'b0;
            req_addr_q       <= 32'h0;
            req_from_br_q    <= 1'b0;
            req_stale_q      <= 1'b0;
        end else begin
            fs_valid_q       <= fs_valid_d;
            fs_pc_q          <= fs_pc_d;
            fs_waiting_q     <= fs_waiting_d;
            inst_buf_q       <= inst_buf_d;
            inst_buf_valid_q <= inst_buf_valid_d;
            br_buf_valid_q   <= br_buf_valid_d;
            br_buf_target_q  <= br_buf_target_d;
            cancel_q         <= cancel_d;
            req_hold_q       <= req_hold_d;
            req_addr_q       <= req_addr_d;
            req_from_br_q    <= req_from_br_d;
            req_stale_q      <= req_stale_d;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline. Sits in front of the decode stage.
- Generates sequential and redirected PCs and issues fetches to the instruction SRAM over a req/addr_ok/data_ok interface.
- Sends {inst, pc} to decode with a valid/allowin handshake.
- Consumes decode's {br_taken, br_target} redirect and cancels wrong-path fetches.

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ds_allowin  in  1  decode can accept a new instruction this cycle.
- br_collect  in  33  {br_taken, br_target}; br_taken is a single-cycle pulse from decode.
- fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
- fs_to_ds_bus  out  64  {inst[31:0], pc[31:0]}.
- inst_sram_req  out  1  fetch request.
- inst_sram_wr  out  1  tied 0.
- inst_sram_size  out  2  tied 2'd2 (word).
- inst_sram_wstrb  out  4  tied 0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  tied 0.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data returned this cycle.
- inst_sram_rdata  in  32  instruction word, valid with data_ok.

Behaviour:
- **State:** fs_valid, fs_pc, fs_waiting (accepted, data not yet back), inst_buf/inst_buf_valid, br_buf_valid/br_buf_target, cancel (drop next data_ok), req_hold.
- **Reset:**
  - fs_valid, fs_waiting, inst_buf_valid, br_buf_valid, cancel, req_hold all cleared.
  - fs_pc = RESET_PC - 4.
  - inst_sram_req = 0 and fs_to_ds_valid = 0 during reset.
  - Reset asserted mid-transaction abandons all state. The SRAM is reset with the core.
- **Outstanding limit:** at most one request outstanding (accepted but no data_ok).
- **Next PC selection:**
  - br_taken this cycle: br_target.
  - Otherwise, br_buf_valid: br_buf_target.
  - Otherwise: fs_pc + 4, 32-bit wrap.
  - Selection happens only when a new request is started. Once req is high, addr and req stay stable until addr_ok (req_hold).
- **Request start condition:**
  - Not in reset, and no outstanding fetch (or its data_ok arrives this cycle).
  - Stage free: ~fs_valid, or fs_ready_go & ds_allowin, or br_taken.
  - The combinational data_ok→req path is permitted.
- **On req & addr_ok:**
  - fs_valid = 1, fs_pc = addr, fs_waiting = 1.
  - If addr was br_buf_target, br_buf_valid = 0.
  - If a redirect arrived while this request was held (addr is wrong-path), cancel = 1 and fs_valid = 0.
- **Ready-go:** fs_ready_go = inst_buf_valid | (fs_waiting & data_ok & ~cancel).
- **Decode handshake:**
  - fs_to_ds_valid = fs_valid & fs_ready_go.
  - Bus inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
  - Transfer occurs when fs_to_ds_valid & ds_allowin.
- **Data returned while decode stalls:** data_ok & ~cancel & ~ds_allowin captures rdata into inst_buf (inst_buf_valid = 1). The buffer clears on transfer.
- **Cancelled return:** data_ok while cancel clears cancel. The data is dropped, no output.
- **br_taken (pulse), all same-cycle:**
  - fs_valid = 0 and inst_buf_valid = 0. The instruction in fs is wrong-path; decode already ignores fs_to_ds_valid this cycle.
  - If fs_waiting with no data_ok this cycle, cancel = 1.
  - If no new request with addr = br_target is accepted this cycle, br_buf_valid = 1 and br_buf_target = br_target.
  - A held seq request not yet accepted stays; it is marked for cancel on acceptance.
- **Simultaneous events:**
  - br_taken and data_ok in the same cycle: data dropped, cancel not set.
  - br_taken and addr_ok of a seq request in the same cycle: that request is cancelled.
- **Throughput:** 1 instruction/cycle when addr_ok and data_ok return in consecutive cycles and ds_allowin = 1.

Test Plan:
1. Reset 3 cycles, release; addr_ok = 1, data_ok one cycle later, ds_allowin = 1 → addrs 1c000000, 1c000004, 1c000008 on consecutive cycles; fs_to_ds_bus = {rdata, 1c000000} etc. with no bubbles.
2. ds_allowin = 0 for 4 cycles when data for 1c000004 returns → inst held in inst_buf; no new req; on allowin = 1 the bus shows buffered inst, pc 1c000004, then the next req is 1c000008.
3. br_taken with target 1c000100 while fetch of 1c000008 is outstanding → that data_ok is dropped (no valid); next req addr = 1c000100; output pc 1c000100.
4. br_taken in the same cycle as data_ok of the wrong path → no fs_to_ds_valid for it, cancel not set; the next accepted addr is the target and its data is delivered.
5. addr_ok held 0 for 3 cycles with req high, br_taken (1c000200) in the 2nd cycle → addr stable at the seq value until accepted; its data is discarded; the following req = 1c000200.
6. Reset asserted while a request is outstanding → outputs cleared next cycle; the first post-reset req addr = 1c000000.
